// File: rtl/sd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_arb_pkg
//  Description : Shared definitions for the SD access arbiter: FSM state
//                encodings, default data/address widths, the owner encoding
//                and a small owner-to-one-hot helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_arb_pkg;

    // Default widths: one SD sector per block, 32-bit block addressing
    localparam int c_BLK_W_DEF  = 4096;
    localparam int c_ADDR_W_DEF = 32;

    // FSM encoding; the numeric values are visible on the debug state port
    typedef logic [3:0] state_t;
    localparam state_t c_ST_IDLE  = 4'd0;
    localparam state_t c_ST_GRANT = 4'd1;
    localparam state_t c_ST_ISSUE = 4'd2;
    localparam state_t c_ST_WAIT  = 4'd3;
    localparam state_t c_ST_ACK   = 4'd4;

    // Owner encoding: 0 = m0 (DDR refill/read path), 1 = m1 (writeback path)
    localparam logic c_OWNER_M0 = 1'b0;
    localparam logic c_OWNER_M1 = 1'b1;

    // Bit N set for owner N
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sd_rr_pick
//  Description : Combinational 2-way round-robin picker.
//  Ports       : req[1:0]   - request vector (bit N = requester N)
//                last_grant - requester served most recently
//                mask[1:0]  - requesters excluded from this decision
//                valid      - at least one unmasked request present
//                winner     - index of the chosen requester
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic [1:0] mask,
    output logic       valid,
    output logic       winner
);

    logic [1:0] w_eff_req;

    assign w_eff_req = req & ~mask;
    assign valid     = |w_eff_req;

    always_comb begin
        // On a tie the requester that was not served last goes next;
        // otherwise the single active requester wins.
        if (w_eff_req == 2'b11) begin
            winner = ~last_grant;
        end else begin
            winner = w_eff_req[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sd_access_arbiter
//  Description : Shares one SD block controller between two requesters
//                (m0 = DDR refill/read, m1 = dirty-page writeback). One whole
//                block transaction at a time, round-robin fairness, a single
//                re/we strobe per transaction and a one-cycle ack on completion.
//  Ports       : clk, reset (async, active-high)
//                mN_req/we/addr/wdata  - requester command (N = 0, 1)
//                mN_ack/rdata          - requester completion and read block
//                sd_re/sd_we           - one-cycle strobes to the controller
//                sd_addr_read/write    - latched block address
//                sd_wdata              - latched write block
//                sd_rdata/ready/done   - controller status and read data
//                err                   - timeout flag, valid during the ack
//                busy                  - FSM not in IDLE
//                state                 - FSM encoding for debug LEDs
//  Config      : SD_ARB_TIMEOUT_EN - when defined, a WAIT watchdog of
//                TIMEOUT_CYC cycles forces an ack with err=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_access_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          BLK_W       = c_BLK_W_DEF,
    parameter int          ADDR_W      = c_ADDR_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 10000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [BLK_W-1:0]  m0_wdata,
    output logic              m0_ack,
    output logic [BLK_W-1:0]  m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [BLK_W-1:0]  m1_wdata,
    output logic              m1_ack,
    output logic [BLK_W-1:0]  m1_rdata,
    output logic              sd_re,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr_read,
    output logic [ADDR_W-1:0] sd_addr_write,
    output logic [BLK_W-1:0]  sd_wdata,
    input  logic [BLK_W-1:0]  sd_rdata,
    input  logic              sd_ready,
    input  logic              sd_done,
    output logic              err,
    output logic              busy,
    output logic [3:0]        state
);

    state_t            r_state_q,      w_state_d;
    logic              r_owner_q,      w_owner_d;
    logic              r_last_grant_q, w_last_grant_d;
    logic [1:0]        r_mask_q,       w_mask_d;
    logic              r_cmd_we_q,     w_cmd_we_d;
    logic [ADDR_W-1:0] r_cmd_addr_q,   w_cmd_addr_d;
    logic [BLK_W-1:0]  r_cmd_wdata_q,  w_cmd_wdata_d;
    logic [BLK_W-1:0]  r_m0_rdata_q,   w_m0_rdata_d;
    logic [BLK_W-1:0]  r_m1_rdata_q,   w_m1_rdata_d;
    logic              r_sd_re_q,      w_sd_re_d;
    logic              r_sd_we_q,      w_sd_we_d;
    logic [1:0]        r_ack_q,        w_ack_d;
    logic              r_err_q,        w_err_d;
    logic              r_busy_q,       w_busy_d;
`ifdef SD_ARB_TIMEOUT_EN
    logic [31:0]       r_wait_cnt_q,   w_wait_cnt_d;
`endif

    logic w_pick_valid;
    logic w_pick_winner;

    sd_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (r_last_grant_q),
        .mask       (r_mask_q),
        .valid      (w_pick_valid),
        .winner     (w_pick_winner)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_owner_d      = r_owner_q;
        w_last_grant_d = r_last_grant_q;
        w_mask_d       = 2'b00;          // mask lives for a single IDLE cycle
        w_cmd_we_d     = r_cmd_we_q;
        w_cmd_addr_d   = r_cmd_addr_q;
        w_cmd_wdata_d  = r_cmd_wdata_q;
        w_m0_rdata_d   = r_m0_rdata_q;
        w_m1_rdata_d   = r_m1_rdata_q;
        w_sd_re_d      = 1'b0;
        w_sd_we_d      = 1'b0;
        w_ack_d        = 2'b00;
        w_err_d        = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        w_wait_cnt_d   = r_wait_cnt_q;
`endif

        case (r_state_q)
            c_ST_IDLE: begin
                // The winner is remembered here because the picker inputs
                // (requests, mask) may differ by the time GRANT executes.
                if (w_pick_valid) begin
                    w_owner_d = w_pick_winner;
                    w_state_d = c_ST_GRANT;
                end
            end

            c_ST_GRANT: begin
                if (r_owner_q == c_OWNER_M1) begin
                    w_cmd_we_d    = m1_we;
                    w_cmd_addr_d  = m1_addr;
                    w_cmd_wdata_d = m1_wdata;
                end else begin
                    w_cmd_we_d    = m0_we;
                    w_cmd_addr_d  = m0_addr;
                    w_cmd_wdata_d = m0_wdata;
                end
                w_state_d = c_ST_ISSUE;
            end

            c_ST_ISSUE: begin
                if (sd_ready) begin
                    w_sd_re_d = ~r_cmd_we_q;
                    w_sd_we_d = r_cmd_we_q;
                    w_state_d = c_ST_WAIT;
`ifdef SD_ARB_TIMEOUT_EN
                    w_wait_cnt_d = 32'd0;
`endif
                end
            end

            c_ST_WAIT: begin
`ifdef SD_ARB_TIMEOUT_EN
                w_wait_cnt_d = r_wait_cnt_q + 32'd1;
`endif
                if (sd_done) begin
                    if (!r_cmd_we_q) begin
                        if (r_owner_q == c_OWNER_M1) begin
                            w_m1_rdata_d = sd_rdata;
                        end else begin
                            w_m0_rdata_d = sd_rdata;
                        end
                    end
                    w_ack_d   = owner_onehot(r_owner_q);
                    w_state_d = c_ST_ACK;
                end
`ifdef SD_ARB_TIMEOUT_EN
                // Count reaches the limit at the end of the TIMEOUT_CYC-th
                // WAIT cycle; read data is deliberately left untouched.
                else if (w_wait_cnt_d == TIMEOUT_CYC) begin
                    w_ack_d   = owner_onehot(r_owner_q);
                    w_err_d   = 1'b1;
                    w_state_d = c_ST_ACK;
                end
`endif
            end

            c_ST_ACK: begin
                w_last_grant_d = r_owner_q;
                w_mask_d       = owner_onehot(r_owner_q);
                w_state_d      = c_ST_IDLE;
            end

            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != c_ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q      <= c_ST_IDLE;
            r_owner_q      <= c_OWNER_M0;
            r_last_grant_q <= c_OWNER_M1;    // m0 wins the first tie
            r_mask_q       <= 2'b00;
            r_cmd_we_q     <= 1'b0;
            r_cmd_addr_q   <= '0;
            r_cmd_wdata_q  <= '0;
            r_m0_rdata_q   <= '0;
            r_m1_rdata_q   <= '0;
            r_sd_re_q      <= 1'b0;
            r_sd_we_q      <= 1'b0;
            r_ack_q        <= 2'b00;
            r_err_q        <= 1'b0;
            r_busy_q       <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            r_wait_cnt_q   <= 32'd0;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_owner_q      <= w_owner_d;
            r_last_grant_q <= w_last_grant_d;
            r_mask_q       <= w_mask_d;
            r_cmd_we_q     <= w_cmd_we_d;
            r_cmd_addr_q   <= w_cmd_addr_d;
            r_cmd_wdata_q  <= w_cmd_wdata_d;
            r_m0_rdata_q   <= w_m0_rdata_d;
            r_m1_rdata_q   <= w_m1_rdata_d;
            r_sd_re_q      <= w_sd_re_d;
            r_sd_we_q      <= w_sd_we_d;
            r_ack_q        <= w_ack_d;
            r_err_q        <= w_err_d;
            r_busy_q       <= w_busy_d;
`ifdef SD_ARB_TIMEOUT_EN
            r_wait_cnt_q   <= w_wait_cnt_d;
`endif
        end
    end

    assign m0_ack        = r_ack_q[0];
    assign m1_ack        = r_ack_q[1];
    assign m0_rdata      = r_m0_rdata_q;
    assign m1_rdata      = r_m1_rdata_q;
    assign sd_re         = r_sd_re_q;
    assign sd_we         = r_sd_we_q;
    assign sd_addr_read  = r_cmd_addr_q;
    assign sd_addr_write = r_cmd_addr_q;
    assign sd_wdata      = r_cmd_wdata_q;
    assign err           = r_err_q;
    assign busy          = r_busy_q;
    assign state         = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_access_arbiter
//  Description : Directed self-checking bench for sd_access_arbiter with a
//                64-bit block so read patterns stay readable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_access_arbiter;

    localparam int BW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [BW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [BW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [BW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [BW-1:0] m1_rdata;
    logic          sd_re, sd_we;
    logic [AW-1:0] sd_addr_read, sd_addr_write;
    logic [BW-1:0] sd_wdata;
    logic [BW-1:0] sd_rdata = '0;
    logic          sd_ready = 1'b0;
    logic          sd_done = 1'b0;
    logic          err, busy;
    logic [3:0]    state;

    int n_checks = 0;
    int n_fail   = 0;
    int re_n = 0, we_n = 0, m0_ack_n = 0, m1_ack_n = 0;

    sd_access_arbiter #(
        .BLK_W       (BW),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_req        (m0_req),
        .m0_we         (m0_we),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_ack        (m0_ack),
        .m0_rdata      (m0_rdata),
        .m1_req        (m1_req),
        .m1_we         (m1_we),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_ack        (m1_ack),
        .m1_rdata      (m1_rdata),
        .sd_re         (sd_re),
        .sd_we         (sd_we),
        .sd_addr_read  (sd_addr_read),
        .sd_addr_write (sd_addr_write),
        .sd_wdata      (sd_wdata),
        .sd_rdata      (sd_rdata),
        .sd_ready      (sd_ready),
        .sd_done       (sd_done),
        .err           (err),
        .busy          (busy),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Strobe / ack event counters, sampled away from the active edge
    always @(negedge clk) begin
        if (sd_re)  re_n++;
        if (sd_we)  we_n++;
        if (m0_ack) m0_ack_n++;
        if (m1_ack) m1_ack_n++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Bounded wait for a given FSM state; an expired bound shows up as a failed check
    task automatic wait_state(input string tag, input logic [3:0] s);
        int n = 0;
        while (state !== s && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, state, s);
    endtask

    // One-cycle controller completion; returns on the ACK-cycle negedge
    task automatic pulse_done(input logic [BW-1:0] rd);
        sd_done  = 1'b1;
        sd_rdata = rd;
        @(negedge clk);
        sd_done  = 1'b0;
        sd_rdata = '0;
    endtask

    logic [BW-1:0] pat_a5;
    logic [BW-1:0] pat_wr;
    int            saved0, saved1;

    initial begin
        pat_a5 = {(BW/8){8'hA5}};
        pat_wr = 64'h1234_5678_9ABC_DEF0;

        // ---------------- reset state ----------------
        @(negedge clk);
        do_reset();
        check("rst_state", state, 4'd0);
        check("rst_busy",  busy, 1'b0);
        check("rst_strb",  {sd_re, sd_we, m0_ack, m1_ack, err}, 5'b0);
        check("rst_addr",  sd_addr_read, 32'd0);
        check("rst_rdata", m0_rdata, 64'd0);

        // ---------------- m0 read, addr 5 ----------------
        sd_ready = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd5;
        wait_state("t1_wait", 4'd3);
        check("t1_re",    sd_re, 1'b1);
        check("t1_raddr", sd_addr_read, 32'd5);
        check("t1_busy",  busy, 1'b1);
        repeat (20) @(negedge clk);
        check("t1_re_cnt",    re_n, 1);
        check("t1_noack",     m0_ack_n, 0);
        pulse_done(pat_a5);
        check("t1_state_ack", state, 4'd4);
        check("t1_ack",       {m1_ack, m0_ack}, 2'b01);
        check("t1_rdata",     m0_rdata, pat_a5);
        check("t1_err",       err, 1'b0);
        // m0 misbehaves by holding req one cycle past ack: masked, no regrant
        @(negedge clk);
        check("t1_idle", state, 4'd0);
        @(negedge clk);
        check("t1_mask", state, 4'd0);
        m0_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_ack_cnt", {m0_ack_n[7:0], m1_ack_n[7:0]}, 16'h0100);

        // ---------------- simultaneous requests after reset ----------------
        do_reset();
        re_n = 0; m0_ack_n = 0; m1_ack_n = 0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd2;
        wait_state("t2_wait_a", 4'd3);
        check("t2_first_m0", sd_addr_read, 32'd1);
        pulse_done(64'h11);
        check("t2_ack_m0", {m1_ack, m0_ack}, 2'b01);
        check("t2_rd_m0",  m0_rdata, 64'h11);
        m0_req = 1'b0;
        wait_state("t2_wait_b", 4'd3);
        check("t2_second_m1", sd_addr_read, 32'd2);
        pulse_done(64'h22);
        check("t2_ack_m1", {m1_ack, m0_ack}, 2'b10);
        check("t2_rd_m1",  m1_rdata, 64'h22);
        check("t2_rd_m0_keep", m0_rdata, 64'h11);
        m1_req = 1'b0;
        repeat (3) @(negedge clk);
        // Tie again with no mask active: last_grant=m1 so m0 wins
        m0_req = 1'b1; m0_addr = 32'd3;
        m1_req = 1'b1; m1_addr = 32'd4;
        wait_state("t2_wait_c", 4'd3);
        check("t2_third_m0", sd_addr_read, 32'd3);
        pulse_done(64'h33);
        check("t2_ack_m0b", {m1_ack, m0_ack}, 2'b01);
        m0_req = 1'b0;
        wait_state("t2_wait_d", 4'd3);
        pulse_done(64'h44);
        m1_req = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- m1 write with sd_ready held low ----------------
        we_n = 0;
        sd_ready = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd9; m1_wdata = pat_wr;
        wait_state("t3_issue", 4'd2);
        repeat (10) @(negedge clk);
        check("t3_hold_state", state, 4'd2);
        check("t3_no_we",      we_n, 0);
        sd_ready = 1'b1;
        @(negedge clk);
        check("t3_we",     {sd_we, sd_re}, 2'b10);
        check("t3_waddr",  sd_addr_write, 32'd9);
        check("t3_wdata",  sd_wdata, pat_wr);
        m1_wdata = '0;   // changes after GRANT must not matter
        @(negedge clk);
        check("t3_we_once", sd_we, 1'b0);
        check("t3_wdata_hold", sd_wdata, pat_wr);
        pulse_done(64'hDEAD);
        check("t3_ack",     {m1_ack, m0_ack}, 2'b10);
        check("t3_rd_keep", m1_rdata, 64'h44);
        m1_req = 1'b0; m1_we = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- sd_done outside WAIT ----------------
        saved0 = m0_ack_n; saved1 = m1_ack_n;
        pulse_done(64'hBAD);
        check("t4_idle_done", state, 4'd0);
        sd_ready = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd7;
        wait_state("t4_issue", 4'd2);
        pulse_done(64'hBAD);
        check("t4_issue_done", state, 4'd2);
        repeat (2) @(negedge clk);
        check("t4_no_ack", m0_ack_n + m1_ack_n, saved0 + saved1);
        sd_ready = 1'b1;
        wait_state("t4_wait", 4'd3);
        pulse_done(64'h77);
        check("t4_rd", m0_rdata, 64'h77);
        m0_req = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- reset during WAIT ----------------
        m0_req = 1'b1; m0_addr = 32'd8;
        wait_state("t5_wait", 4'd3);
        reset = 1'b1;
        m0_req = 1'b0;
        #1;
        check("t5_async", {sd_re, sd_we, busy, state}, 7'd0);
        check("t5_rdata", m0_rdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saved0 = m0_ack_n;
        @(negedge clk);
        pulse_done(64'h99);
        repeat (2) @(negedge clk);
        check("t5_no_ack", m0_ack_n, saved0);
        check("t5_idle",   state, 4'd0);

`ifdef SD_ARB_TIMEOUT_EN
        // ---------------- watchdog ----------------
        begin
            int n;
            m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd12;
            wait_state("t6_wait", 4'd3);
            n = 0;
            while (state == 4'd3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("t6_cycles", n, 100);
            check("t6_ack",    {m1_ack, m0_ack}, 2'b10);
            check("t6_err",    err, 1'b1);
            check("t6_rd",     m1_rdata, 64'h0);
            m1_req = 1'b0;
            @(negedge clk);
            check("t6_idle", {state, err}, 5'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_access_arbiter.md
Name: sd_access_arbiter

Overview:
- Shares the single SD block controller between two requesters: m0 is the DDR refill/read path, m1 is the dirty-page writeback path.
- Grants one whole-block transaction at a time, with round-robin fairness.
- Latches the winner's command, issues exactly one re/we pulse to the controller, waits for completion, then returns read data plus a one-cycle ack.
- Sits between the storage-hierarchy page manager and the SD controller.

Parameters:
BLK_W, 4096, block data width in bits (one SD sector)
ADDR_W, 32, SD block address width
TIMEOUT_CYC, 10000000, WAIT-state watchdog limit in clk cycles (used only with SD_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock; single clock domain, all logic on posedge
reset  in  1  asynchronous, active-high reset
m0_req  in  1  requester 0 transaction request, held until m0_ack
m0_we  in  1  requester 0: 1 = write, 0 = read
m0_addr  in  ADDR_W  requester 0 block address
m0_wdata  in  BLK_W  requester 0 write block
m0_ack  out  1  requester 0 completion pulse
m0_rdata  out  BLK_W  requester 0 read block
m1_req/m1_we/m1_addr/m1_wdata/m1_ack/m1_rdata  same as m0, for requester 1
sd_re  out  1  read strobe to controller
sd_we  out  1  write strobe to controller
sd_addr_read  out  ADDR_W  controller read address
sd_addr_write  out  ADDR_W  controller write address
sd_wdata  out  BLK_W  controller write block
sd_rdata  in  BLK_W  controller read block, valid when sd_done=1
sd_ready  in  1  controller idle and able to accept a command
sd_done  in  1  one-cycle pulse when the controller finishes a transaction
err  out  1  timeout flag, valid during the ack cycle
busy  out  1  high in any state except IDLE
state  out  4  FSM encoding, for LED debug

Behaviour:
- Reset (asynchronous, takes effect immediately): every output goes to 0, including both rdata buses and both sd addresses. FSM goes to IDLE. last_grant resets to 1, so m0 wins the first tie. Any in-flight transaction is abandoned and no ack is issued for it.
- States and transitions:
  - IDLE=0: pick a requester (rules below). If there is one, go to GRANT.
  - GRANT=1: latch the chosen master's we, addr and wdata into cmd registers; record owner; go to ISSUE.
  - ISSUE=2: wait while sd_ready=0. When sd_ready=1, assert sd_re (read) or sd_we (write) for exactly one cycle, then go to WAIT.
  - WAIT=3: on sd_done=1, capture sd_rdata into the owner's rdata register (reads only), then go to ACK.
  - ACK=4: pulse the owner's ack for 1 cycle; set last_grant=owner; go to IDLE.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesting: the one that is not last_grant wins.
  - The master acked in the previous cycle is masked for that one IDLE cycle; it must drop req on seeing ack.
- sd_addr_read and sd_addr_write are both driven from the latched address register. sd_wdata is driven from the latched wdata register. All stay stable from GRANT until the next GRANT.
- Requester inputs are sampled only in GRANT. Changes after GRANT do not affect the transaction in flight.
- mN_rdata holds its value until that master's next read completes. Writes leave rdata unchanged.
- sd_done outside WAIT is ignored. sd_done in the same cycle as the strobe is not possible, because the strobe is issued in ISSUE.
- Minimum latency from req to ack: 4 cycles plus controller time.
- err is low on normal completion.

Optional Feature:
- SD_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without sd_done, go to ACK with err=1 for that cycle. rdata is not updated.
- Undefined: no counter is built, err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package sd_arb_pkg holds: state localparams IDLE..ACK, BLK_W and ADDR_W defaults, and the owner encoding (0 = m0, 1 = m1).
- One natural sub-module: sd_rr_pick, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, mask[1:0].
  - Outputs: valid, winner.

Test Plan:
- m0 read, addr=5; sd_ready=1; sd_done after 20 cycles with rdata=0xA5 pattern -> single sd_re pulse with sd_addr_read=5; one m0_ack; m0_rdata=pattern; m1_ack stays 0.
- m0 and m1 request together right after reset -> m0 served first, then m1. A simultaneous re-request -> m0 again (last_grant=1).
- m1 write, addr=9, wdata=0x1234..., sd_ready low for 10 cycles -> sd_we not asserted until the cycle sd_ready=1; sd_addr_write=9; sd_wdata=m1_wdata; m1_rdata unchanged.
- sd_done pulsed while in IDLE and while in ISSUE -> no ack, state unaffected.
- reset asserted in WAIT -> sd_re/sd_we/busy/state=0 in the same cycle; a later sd_done produces no ack.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYC=100, withhold sd_done -> ack with err=1 exactly 100 WAIT cycles in; rdata unchanged; FSM returns to IDLE.
